// File: rtl/mult_arbiter_if.sv
// Bundle of requester, multiplier and status signals around mult_arbiter.
// slave is the arbiter's view; master is the view of whoever drives requests and the multiplier.
interface mult_arbiter_if #(
    parameter int WIDTH = 24
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] res0;
    logic [WIDTH-1:0] res1;
    logic             mult_start;
    logic [WIDTH-1:0] mult_a;
    logic [WIDTH-1:0] mult_b;
    logic [WIDTH-1:0] mult_out;
    logic             mult_done;
    logic             busy;
    logic             err;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, mult_out, mult_done,
        output gnt0, gnt1, done0, done1, res0, res1,
        output mult_start, mult_a, mult_b, busy, err
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, mult_out, mult_done,
        input  gnt0, gnt1, done0, done1, res0, res1,
        input  mult_start, mult_a, mult_b, busy, err
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between two requesters (IDLE/ISSUE/WAIT/DONE).
// Optional WAIT watchdog compiled in with macro MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 63
) (
    input  logic           CLK,
    input  logic           RST,
    mult_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             ptr_reg;
    logic [1:0]       gnt_reg;
    logic [WIDTH-1:0] mult_a_reg;
    logic [WIDTH-1:0] mult_b_reg;
    logic [1:0]       done_vec;
    logic             any_req;
    logic             winner;
    logic             timeout;
    logic             capture;
    logic [WIDTH-1:0] capture_val;

    assign any_req = bus.req0 | bus.req1;
    // Pointer only breaks ties; a lone requester always wins.
    assign winner  = (bus.req0 & bus.req1) ? ptr_reg : bus.req1;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_reg;
    logic          err_reg;

    assign timeout = (state_reg == WAIT) && !bus.mult_done && (wd_cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (state_reg == ISSUE)
                wd_cnt_reg <= '0;
            else if (state_reg == WAIT && !bus.mult_done)
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            if (timeout)
                err_reg <= 1'b1;
        end
    end

    assign bus.err = err_reg;
`else
    // No watchdog: only a (never legal) negative TIMEOUT could make this true.
    assign timeout = (TIMEOUT < 0);
    assign bus.err = 1'b0;
`endif

    assign capture     = (state_reg == WAIT) && (bus.mult_done || timeout);
    assign capture_val = bus.mult_done ? bus.mult_out : {WIDTH{1'b1}};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (bus.mult_done || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= IDLE;
            ptr_reg    <= 1'b0;
            gnt_reg    <= 2'b00;
            mult_a_reg <= '0;
            mult_b_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        gnt_reg    <= winner ? 2'b10 : 2'b01;
                        mult_a_reg <= winner ? bus.a1 : bus.a0;
                        mult_b_reg <= winner ? bus.b1 : bus.b0;
                    end
                end
                DONE: begin
                    gnt_reg <= 2'b00;
                    ptr_reg <= gnt_reg[0];
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [WIDTH-1:0] res_reg;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    res_reg <= '0;
                else if (capture && gnt_reg[gi])
                    res_reg <= capture_val;
            end

            assign done_vec[gi] = (state_reg == DONE) && gnt_reg[gi];
        end
    endgenerate

    assign bus.gnt0       = gnt_reg[0];
    assign bus.gnt1       = gnt_reg[1];
    assign bus.done0      = done_vec[0];
    assign bus.done1      = done_vec[1];
    assign bus.res0       = g_req[0].res_reg;
    assign bus.res1       = g_req[1].res_reg;
    assign bus.mult_start = (state_reg == ISSUE);
    assign bus.mult_a     = mult_a_reg;
    assign bus.mult_b     = mult_b_reg;
    assign bus.busy       = (state_reg != IDLE);
endmodule
